// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_e;

  localparam int          INST_BYTES    = 4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int          ENTRY_W       = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetchEntry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with push/pop/flush; head holds its last value when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] headData
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wrPtr, rdPtr;
  logic [W-1:0]            holdData;
  logic                    doPush, doPop;

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPush   = push && (!full || pop) && !flush;
  assign doPop    = pop && !empty && !flush;
  assign headData = empty ? holdData : mem[rdPtr[AW-1:0]];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gSlot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem[g] <= '0;
        else if (doPush && (wrPtr[AW-1:0] == AW'(g)))
          mem[g] <= pushData;
      end
    end
  endgenerate

  // holdData tracks whatever was last presented so the head is stable across empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      holdData <= '0;
    end else begin
      holdData <= headData;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + 1'b1;
        if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, BOOT/RUN/HALT control, ROM response qualification and decode buffer.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] memAddr,
  input  logic [31:0] memData,
  input  logic [31:0] memAddrEcho,
  input  logic        memReadValid,
  input  logic        memReady,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        haltReq,
  output logic        instValid,
  input  logic        instReady,
  output logic [31:0] instData,
  output logic [31:0] instPc,
  output logic        halted,
  output logic [31:0] perfFetchCnt,
  output logic [31:0] perfStallCnt
);
  fetchState_e state, nextState;
  logic [31:0] pc;
  logic        full, empty, pop, accept;
  fetchEntry_t pushEntry, headEntry;

  assign memAddr   = pc;
  assign instValid = !empty;
  assign pop       = instValid && instReady;
  assign halted    = (state == HALT);
  assign accept    = (state == RUN) && memReady && memReadValid && (memAddrEcho == pc)
                     && !redirectValid && (!full || pop);
  assign pushEntry = '{pc: pc, inst: memData};
  assign instPc    = headEntry.pc;
  assign instData  = headEntry.inst;

  always_comb begin
    nextState = state;
    unique case (state)
      BOOT:    nextState = RUN;
      RUN:     if (haltReq && !redirectValid) nextState = HALT;
      HALT:    if (redirectValid) nextState = RUN;
      default: nextState = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC & PC_ALIGN_MASK;
    end else begin
      state <= nextState;
      if (redirectValid)
        pc <= redirectPc & PC_ALIGN_MASK;
      else if (accept)
        pc <= pc + 32'(INST_BYTES);
    end
  end

  // Redirect flushes the buffer; any same-cycle pop is simply lost with it.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .pushData (pushEntry),
    .pop      (pop),
    .flush    (redirectValid),
    .full     (full),
    .empty    (empty),
    .headData (headEntry)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetchCnt <= '0;
      perfStallCnt <= '0;
    end else begin
      if (accept) perfFetchCnt <= perfFetchCnt + 1'b1;
      if ((state == RUN) && full && !pop) perfStallCnt <= perfStallCnt + 1'b1;
    end
  end
`else
  assign perfFetchCnt = '0;
  assign perfStallCnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomised bench for fetch_unit with a queue-based scoreboard of expected {pc, inst}.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam int S_BOOT = 0, S_RUN = 1, S_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] memAddr, memData, memAddrEcho, redirectPc;
  logic        memReadValid, memReady, redirectValid, haltReq;
  logic        instValid, instReady, halted;
  logic [31:0] instData, instPc, perfFetchCnt, perfStallCnt;

  logic        echoOvr;
  logic [31:0] echoVal;

  int          vectors = 0;
  int          errs    = 0;

  logic [63:0] q[$];
  logic [31:0] mPc, mFetch, mStall;
  int          mState;

  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h3701_0080;
    if (a == 32'h4) return 32'h9300_1002;
    return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  assign memData     = romWord(memAddr);
  assign memAddrEcho = echoOvr ? echoVal : memAddr;

  fetch_unit #(.RESET_PC(32'h0000_0003), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .memAddr(memAddr), .memData(memData),
    .memAddrEcho(memAddrEcho), .memReadValid(memReadValid), .memReady(memReady),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .haltReq(haltReq),
    .instValid(instValid), .instReady(instReady), .instData(instData), .instPc(instPc),
    .halted(halted), .perfFetchCnt(perfFetchCnt), .perfStallCnt(perfStallCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mPc    = 32'h0;
    mState = S_BOOT;
    mFetch = 32'h0;
    mStall = 32'h0;
  endtask

  task automatic chkPerf();
`ifdef FETCH_PERF_CNT_EN
    chk("perfFetchCnt", perfFetchCnt, mFetch);
    chk("perfStallCnt", perfStallCnt, mStall);
`else
    chk("perfFetchCnt", perfFetchCnt, 32'h0);
    chk("perfStallCnt", perfStallCnt, 32'h0);
`endif
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic mPop, mFull, mAcc;
    logic [31:0] echoUsed;
    #1;
    chk("memAddr", memAddr, mPc);
    chk("instValid", 32'(instValid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instPc", instPc, q[0][63:32]);
      chk("instData", instData, q[0][31:0]);
    end
    chk("halted", 32'(halted), 32'(mState == S_HALT));
    chkPerf();
    mPop     = (q.size() != 0) && instReady;
    mFull    = (q.size() == DEPTH);
    echoUsed = echoOvr ? echoVal : mPc;
    mAcc     = (mState == S_RUN) && memReady && memReadValid && (echoUsed == mPc)
               && !redirectValid && (!mFull || mPop);
    if (mAcc) mFetch = mFetch + 1;
    if ((mState == S_RUN) && mFull && !mPop) mStall = mStall + 1;
    if (redirectValid) q.delete();
    else begin
      if (mPop) void'(q.pop_front());
      if (mAcc) q.push_back({mPc, romWord(mPc)});
    end
    case (mState)
      S_BOOT:  mState = S_RUN;
      S_RUN:   if (haltReq && !redirectValid) mState = S_HALT;
      default: if (redirectValid) mState = S_RUN;
    endcase
    if (redirectValid) mPc = redirectPc & 32'hFFFF_FFFC;
    else if (mAcc) mPc = mPc + 32'd4;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; instReady = 1'b1; memReady = 1'b1; memReadValid = 1'b1;
    redirectValid = 1'b0; redirectPc = '0; haltReq = 1'b0; echoOvr = 1'b0; echoVal = '0;
    modelReset();
    #1;
    chk("rst memAddr", memAddr, 32'h0);
    chk("rst instValid", 32'(instValid), 32'h0);
    chk("rst instPc", instPc, 32'h0);
    chk("rst instData", instData, 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chkPerf();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // boot, then streaming 0,4,8...
    cycles(5);

    // backpressure fills the buffer, then drains in order
    instReady = 1'b0; cycles(6);
    instReady = 1'b1; cycles(4);

    // redirect with a full buffer
    instReady = 1'b0; cycles(3);
    redirectValid = 1'b1; redirectPc = 32'h0000_002E; cycle();
    redirectValid = 1'b0; instReady = 1'b1; cycles(4);
    chk("post-redirect pc region", {memAddr[31:8], 8'h0}, 32'h0);

    // echo mismatch stalls the PC
    redirectValid = 1'b1; redirectPc = 32'h8; cycle();
    redirectValid = 1'b0;
    echoOvr = 1'b1; echoVal = 32'h4; cycles(3);
    echoOvr = 1'b0; cycles(3);

    // invalid data / not ready
    memReadValid = 1'b0; cycles(2);
    memReadValid = 1'b1; memReady = 1'b0; cycle();
    memReady = 1'b1; cycles(2);

    // halt, drain, then redirect out of HALT
    haltReq = 1'b1; cycle();
    haltReq = 1'b0; cycles(4);
    redirectValid = 1'b1; redirectPc = 32'h10; cycle();
    redirectValid = 1'b0; cycles(4);

    // redirect wins over simultaneous halt
    haltReq = 1'b1; redirectValid = 1'b1; redirectPc = 32'h40; cycle();
    haltReq = 1'b0; redirectValid = 1'b0; cycles(3);

    // PC wrap
    redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFF; cycle();
    redirectValid = 1'b0; cycles(4);

    // randomised traffic
    for (int i = 0; i < 80; i++) begin
      instReady     = ($urandom_range(0, 3) != 0);
      memReadValid  = ($urandom_range(0, 4) != 0);
      memReady      = ($urandom_range(0, 5) != 0);
      redirectValid = ($urandom_range(0, 9) == 0);
      redirectPc    = $urandom_range(0, 255);
      haltReq       = ($urandom_range(0, 15) == 0);
      cycle();
    end
    instReady = 1'b1; memReadValid = 1'b1; memReady = 1'b1; haltReq = 1'b0;
    redirectValid = 1'b1; redirectPc = 32'h20; cycle();
    redirectValid = 1'b0; cycles(3);

    // async reset mid-stream with a full buffer
    instReady = 1'b0; cycles(4);
    chk("full before reset", 32'(q.size()), 32'(DEPTH));
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    chk("async rst memAddr", memAddr, 32'h0);
    chk("async rst instValid", 32'(instValid), 32'h0);
    chk("async rst halted", 32'(halted), 32'h0);
    chkPerf();
    @(negedge clk);
    rst_n = 1'b1; instReady = 1'b1;
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
